// File: rtl/pwd_lock_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pwd_pkg
// Purpose  : Shared state encoding and default constants for the password
//            lock access-control sequencer and its timebase.
// Revision : 1.0 - initial release
// ============================================================================
package pwd_pkg;

  // Binary 2-bit encoding; code 2'b11 is unused and recovers to ARMED.
  typedef enum logic [1:0] {
    ST_ARMED    = 2'b00,
    ST_UNLOCKED = 2'b01,
    ST_LOCKOUT  = 2'b10
  } state_t;

  localparam int CLK_FREQ_HZ         = 50_000_000;
  localparam int DEFAULT_MAX_FAILS   = 3;
  localparam int DEFAULT_LOCK_SECS   = 30;
  localparam int DEFAULT_UNLOCK_SECS = 10;

  // Larger of two integers, used to size the shared countdown register.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwd_lock_sequencer_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Restartable tick generator. Emits a one-cycle pulse every
//            CLK_FREQ/TICK_FREQ clocks; restart realigns the period so the
//            next pulse lands exactly TICK_DIV cycles after the restart cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tick_gen
  import pwd_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_HZ,
  parameter int TICK_FREQ = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic restart,
  output logic tick
);

  localparam int c_tick_div = CLK_FREQ / TICK_FREQ;
  localparam int c_cnt_w    = $clog2(c_tick_div);

  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_tick_div - 1);
  // Pulse is registered, so it is raised one count early to coincide with
  // the cycle in which the counter sits at its last value and wraps.
  localparam logic [c_cnt_w-1:0] c_cnt_pre  = c_cnt_w'(c_tick_div - 2);

  logic [c_cnt_w-1:0] r_cnt;
  logic               r_tick;

  // Free-running divider with synchronous clear on reset or restart.
  always_ff @(posedge CLK) begin
    if (RST || restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == c_cnt_last) ? '0 : r_cnt + c_cnt_w'(1);
      r_tick <= (r_cnt == c_cnt_pre);
    end
  end

  assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/pwd_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pwd_lock_sequencer
// Purpose  : Access-control sequencer for the password lock. Tracks
//            consecutive failures, times the UNLOCKED window and the LOCKOUT
//            penalty against a restartable tick, and drives status outputs.
// Revision : 1.0 - initial release
// ============================================================================
module pwd_lock_sequencer
  import pwd_pkg::*;
#(
  parameter int CLK_FREQ    = CLK_FREQ_HZ,
  parameter int TICK_FREQ   = 1,
  parameter int MAX_FAILS   = DEFAULT_MAX_FAILS,
  parameter int LOCK_SECS   = DEFAULT_LOCK_SECS,
  parameter int UNLOCK_SECS = DEFAULT_UNLOCK_SECS
) (
  input  logic                                                  CLK,
  input  logic                                                  RST,
  input  logic                                                  attempt_valid,
  input  logic                                                  attempt_ok,
  input  logic                                                  relock,
  output logic                                                  unlocked,
  output logic                                                  locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]                        fail_count,
  output logic [$clog2(max_int(LOCK_SECS, UNLOCK_SECS)+1)-1:0]  secs_left,
  output logic                                                  reject,
  output logic                                                  tick
);

  localparam int c_fail_w = $clog2(MAX_FAILS + 1);
  localparam int c_sec_w  = $clog2(max_int(LOCK_SECS, UNLOCK_SECS) + 1);

  localparam logic [c_fail_w-1:0] c_max_fails   = c_fail_w'(MAX_FAILS);
  localparam logic [c_sec_w-1:0]  c_lock_secs   = c_sec_w'(LOCK_SECS);
  localparam logic [c_sec_w-1:0]  c_unlock_secs = c_sec_w'(UNLOCK_SECS);
  localparam logic [c_sec_w-1:0]  c_sec_one     = c_sec_w'(1);

  state_t              r_state,    w_state_nxt;
  logic [c_fail_w-1:0] r_fail,     w_fail_nxt, w_fail_inc;
  logic [c_sec_w-1:0]  r_secs,     w_secs_nxt;
  logic                r_reject,   w_reject_nxt;
  logic                r_unlocked, r_locked_out;
  logic                w_restart;
  logic                w_tick;

  tick_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .TICK_FREQ (TICK_FREQ)
  ) u_tick_gen (
    .CLK     (CLK),
    .RST     (RST),
    .restart (w_restart),
    .tick    (w_tick)
  );

  assign w_fail_inc = r_fail + c_fail_w'(1);

  // Next-state, counter updates, reject pulse and timebase restart request.
  always_comb begin
    w_state_nxt  = r_state;
    w_fail_nxt   = r_fail;
    w_secs_nxt   = r_secs;
    w_reject_nxt = 1'b0;
    w_restart    = 1'b0;
    case (r_state)
      ST_ARMED: begin
        if (attempt_valid) begin
          if (attempt_ok) begin
            w_state_nxt = ST_UNLOCKED;
            w_fail_nxt  = '0;
            w_secs_nxt  = c_unlock_secs;
            w_restart   = 1'b1;
          end else if (w_fail_inc == c_max_fails) begin
            w_state_nxt = ST_LOCKOUT;
            w_fail_nxt  = c_max_fails;
            w_secs_nxt  = c_lock_secs;
            w_restart   = 1'b1;
          end else begin
            w_fail_nxt  = w_fail_inc;
          end
        end
      end
      ST_UNLOCKED: begin
        w_reject_nxt = attempt_valid;
        if (relock) begin
          w_state_nxt = ST_ARMED;
          w_secs_nxt  = '0;
        end else if (w_tick) begin
          if (r_secs <= c_sec_one) begin
            w_state_nxt = ST_ARMED;
            w_secs_nxt  = '0;
          end else begin
            w_secs_nxt  = r_secs - c_sec_one;
          end
        end
      end
      ST_LOCKOUT: begin
        w_reject_nxt = attempt_valid;
        w_fail_nxt   = c_max_fails;
        if (w_tick) begin
          if (r_secs <= c_sec_one) begin
            w_state_nxt = ST_ARMED;
            w_fail_nxt  = '0;
            w_secs_nxt  = '0;
          end else begin
            w_secs_nxt  = r_secs - c_sec_one;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ARMED;
        w_fail_nxt  = '0;
        w_secs_nxt  = '0;
      end
    endcase
  end

  // State, counters and status flags, all registered from the next-state view.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= ST_ARMED;
      r_fail       <= '0;
      r_secs       <= '0;
      r_reject     <= 1'b0;
      r_unlocked   <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_fail       <= w_fail_nxt;
      r_secs       <= w_secs_nxt;
      r_reject     <= w_reject_nxt;
      r_unlocked   <= (w_state_nxt == ST_UNLOCKED);
      r_locked_out <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign unlocked   = r_unlocked;
  assign locked_out = r_locked_out;
  assign fail_count = r_fail;
  assign secs_left  = r_secs;
  assign reject     = r_reject;
  assign tick       = w_tick;

endmodule
`default_nettype wire

// File: tb/tb_pwd_lock_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwd_lock_sequencer
// Purpose  : Directed self-checking bench for pwd_lock_sequencer with
//            TICK_DIV=10, MAX_FAILS=3, LOCK_SECS=3, UNLOCK_SECS=2.
//            Cycle A = cycle in which an input is sampled; status shows at A+1.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwd_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       attempt_valid;
  logic       attempt_ok;
  logic       relock;
  logic       unlocked;
  logic       locked_out;
  logic [1:0] fail_count;
  logic [1:0] secs_left;
  logic       reject;
  logic       tick;

  int n_total = 0;
  int n_bad   = 0;

  pwd_lock_sequencer #(
    .CLK_FREQ    (10),
    .TICK_FREQ   (1),
    .MAX_FAILS   (3),
    .LOCK_SECS   (3),
    .UNLOCK_SECS (2)
  ) dut (
    .CLK           (clk),
    .RST           (rst),
    .attempt_valid (attempt_valid),
    .attempt_ok    (attempt_ok),
    .relock        (relock),
    .unlocked      (unlocked),
    .locked_out    (locked_out),
    .fail_count    (fail_count),
    .secs_left     (secs_left),
    .reject        (reject),
    .tick          (tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag, input int unl, input int lo,
                              input int fc, input int sl);
    check_eq({tag, ".unlocked"},   int'(unlocked),   unl);
    check_eq({tag, ".locked_out"}, int'(locked_out), lo);
    check_eq({tag, ".fail_count"}, int'(fail_count), fc);
    check_eq({tag, ".secs_left"},  int'(secs_left),  sl);
  endtask

  // Advance n clock edges and settle just after the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Present one attempt for exactly one sampling edge.
  task automatic attempt_step(input logic okv);
    attempt_valid = 1'b1;
    attempt_ok    = okv;
    step(1);
    attempt_valid = 1'b0;
    attempt_ok    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; attempt_valid = 1'b0; attempt_ok = 1'b0; relock = 1'b0;
    step(3);
    check_status("reset", 0, 0, 0, 0);
    check_eq("reset.reject", int'(reject), 0);
    check_eq("reset.tick",   int'(tick),   0);
    rst = 1'b0;
    step(4);

    // Correct attempt: UNLOCKED for two ticks then auto-relock.
    attempt_step(1'b1);                                   // A+1
    check_status("s1_unlock", 1, 0, 0, 2);
    step(8);  check_eq("s1_no_tick_a9", int'(tick), 0);   // A+9
    step(1);  check_eq("s1_tick_a10",   int'(tick), 1);   // A+10
    check_eq("s1_secs_a10", int'(secs_left), 2);
    step(1);  check_status("s1_a11", 1, 0, 0, 1);         // A+11
    step(9);  check_eq("s1_tick_a20",   int'(tick), 1);   // A+20
    step(1);  check_status("s1_expired", 0, 0, 0, 0);     // A+21

    // Three wrong attempts lead to LOCKOUT.
    attempt_step(1'b0); check_status("s2_fail1", 0, 0, 1, 0);
    attempt_step(1'b0); check_status("s2_fail2", 0, 0, 2, 0);
    attempt_step(1'b0); check_status("s2_lockout", 0, 1, 3, 3);   // C+1

    // Attempts during LOCKOUT are rejected; one lands on the expiry tick.
    step(3);                                              // C+4
    attempt_step(1'b1);                                   // C+5
    check_eq("s3_reject", int'(reject), 1);
    check_status("s3_rej_hold", 0, 1, 3, 3);
    step(1);  check_eq("s3_reject_end", int'(reject), 0); // C+6
    step(4);  check_eq("s3_tick_c10", int'(tick), 1);     // C+10
    step(1);  check_status("s3_c11", 0, 1, 3, 2);         // C+11
    step(9);  check_eq("s3_tick_c20", int'(tick), 1);     // C+20
    step(1);  check_status("s3_c21", 0, 1, 3, 1);         // C+21
    step(9);                                              // C+30
    check_eq("s3_tick_c30", int'(tick), 1);
    check_status("s3_pre_expire", 0, 1, 3, 1);
    attempt_step(1'b0);                                   // C+31
    check_eq("s3_expire_reject", int'(reject), 1);
    check_status("s3_expired", 0, 0, 0, 0);
    step(1);  check_eq("s3_reject_clear", int'(reject), 0);

    // Reject in UNLOCKED, then relock on the same cycle as a tick.
    attempt_step(1'b1);                                   // U+1
    step(2);                                              // U+3
    attempt_step(1'b0);                                   // U+4
    check_eq("s4_reject", int'(reject), 1);
    check_status("s4_rej_hold", 1, 0, 0, 2);
    step(6);  check_eq("s4_tick_u10", int'(tick), 1);     // U+10
    relock = 1'b1; step(1); relock = 1'b0;                // U+11
    check_status("s4_relock", 0, 0, 0, 0);
    relock = 1'b1; step(1); relock = 1'b0;
    check_status("s4_relock_armed", 0, 0, 0, 0);

    // Two failures then success clears the count; a later failure counts 1.
    attempt_step(1'b0);
    attempt_step(1'b0); check_eq("s5_fail2", int'(fail_count), 2);
    attempt_step(1'b1); check_status("s5_unlock", 1, 0, 0, 2);
    relock = 1'b1; step(1); relock = 1'b0;
    check_status("s5_relock", 0, 0, 0, 0);
    attempt_step(1'b0); check_status("s5_one_fail", 0, 0, 1, 0);

    // Reset mid-LOCKOUT with secs_left=2.
    attempt_step(1'b0);
    attempt_step(1'b0); check_status("s6_lockout", 0, 1, 3, 3);   // L+1
    step(9);  check_eq("s6_tick_l10", int'(tick), 1);     // L+10
    step(1);  check_status("s6_l11", 0, 1, 3, 2);         // L+11
    rst = 1'b1; step(1); rst = 1'b0;                      // R+1
    check_status("s6_reset", 0, 0, 0, 0);
    check_eq("s6_reset.reject", int'(reject), 0);
    check_eq("s6_reset.tick",   int'(tick),   0);
    step(8);  check_eq("s6_no_tick_r9", int'(tick), 0);   // R+9
    step(1);  check_eq("s6_tick_r10",   int'(tick), 1);   // R+10

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
